// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and helpers for the VGA raster timing slice.
// Optional frame counter is enabled with the VGA_FRAME_CNT_EN macro.
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
    return vis + fp + sw + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
    return vis + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to pixel generator and VGA connector.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pclk_en;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic valid;
  logic hsync;
  logic vsync;
  logic line_start;
  logic frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
`ifdef VGA_FRAME_CNT_EN
    output frame_cnt,
`endif
    output pclk_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );

  modport slave (
`ifdef VGA_FRAME_CNT_EN
    input frame_cnt,
`endif
    input pclk_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/clk_en_div.sv
// Clock-enable divider: registered one-clk pulse every DIV clocks.
// en_next_out is high in the cycle before en_out, letting consumers update in step with it.
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic en_out,
  output logic en_next_out
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;

  assign en_next_out = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      en_out    <= 1'b0;
    end else begin
      r_div_cnt <= en_next_out ? '0 : r_div_cnt + 1'b1;
      en_out    <= en_next_out;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, h/v counters, registered decodes and strobes.
// Define VGA_FRAME_CNT_EN to add the mod-256 frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end
  if (CLK_DIV < 2) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic w_pclk_en;
  logic w_adv;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk         (clk),
    .rst         (rst),
    .en_out      (w_pclk_en),
    .en_next_out (w_adv)
  );

  cnt_t r_h_cnt;
  cnt_t r_v_cnt;
  cnt_t w_h_nxt;
  cnt_t w_v_nxt;
  logic w_h_wrap;
  logic w_hs_act;
  logic w_vs_act;
  logic w_line_nxt;
  logic r_valid;
  logic r_hsync;
  logic r_vsync;
  logic r_line_start;
  logic r_frame_start;

  // Decodes use next-state counters so they register on the same edge as the counters.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_h_nxt  = r_h_cnt;
    w_v_nxt  = r_v_cnt;
    if (w_adv) begin
      w_h_nxt = w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end
    end
    w_hs_act   = (w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST);
    w_vs_act   = (w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST);
    w_line_nxt = w_adv && (w_h_nxt == '0);
  end

  // Reset parks the raster at the last back-porch pixel so the first enable starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_valid       <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_valid       <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_line_nxt && (w_v_nxt == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_line_nxt && (w_v_nxt == '0)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign vga.frame_cnt = r_frame_cnt;
`endif

  assign vga.pclk_en     = w_pclk_en;
  assign vga.h_cnt       = r_h_cnt;
  assign vga.v_cnt       = r_v_cnt;
  assign vga.valid       = r_valid;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for startup/divider/horizontal checks, and a tiny
// active-high-sync instance for frame wrap, mid-frame reset and (with VGA_FRAME_CNT_EN) frame_cnt.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       pclk_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       ls;
    logic       fs;
  } snap_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  vga_timing_gen u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (vga_a)
  );

  // 8x8 raster, 2 clks per pixel, hsync on h 5..6, vsync on v 5..6, active-high.
  vga_timing_gen #(
    .CLK_DIV   (2),
    .H_VISIBLE (4),
    .H_FP      (1),
    .H_SYNC    (2),
    .H_BP      (1),
    .V_VISIBLE (4),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (1),
    .SYNC_POL  (1'b1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (vga_b)
  );

  snap_t s_a;
  snap_t s_b;
  assign s_a = {vga_a.pclk_en, vga_a.h_cnt, vga_a.v_cnt, vga_a.valid, vga_a.hsync,
                vga_a.vsync, vga_a.line_start, vga_a.frame_start};
  assign s_b = {vga_b.pclk_en, vga_b.h_cnt, vga_b.v_cnt, vga_b.valid, vga_b.hsync,
                vga_b.vsync, vga_b.line_start, vga_b.frame_start};

  function automatic snap_t snap(input bit sel);
    return sel ? s_b : s_a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input bit sel, input string nm, input int h_last,
                                   input int v_last, input logic idle);
    snap_t s;
    s = snap(sel);
    check({nm, "_rst_pclk"},  32'(s.pclk_en), 0);
    check({nm, "_rst_h"},     32'(s.h), h_last);
    check({nm, "_rst_v"},     32'(s.v), v_last);
    check({nm, "_rst_valid"}, 32'(s.valid), 0);
    check({nm, "_rst_hsync"}, 32'(s.hsync), 32'(idle));
    check({nm, "_rst_vsync"}, 32'(s.vsync), 32'(idle));
    check({nm, "_rst_ls"},    32'(s.ls), 0);
    check({nm, "_rst_fs"},    32'(s.fs), 0);
  endtask

  // Call at the negedge where rst was just released (cycle 0).
  task automatic check_startup(input bit sel, input string nm, input int div, input int h_last,
                               input int v_last);
    snap_t s;
    for (int c = 1; c < div; c++) begin
      @(negedge clk);
      s = snap(sel);
      check({nm, "_pre_pclk"}, 32'(s.pclk_en), 0);
      check({nm, "_pre_h"},    32'(s.h), h_last);
      check({nm, "_pre_v"},    32'(s.v), v_last);
    end
    @(negedge clk);
    s = snap(sel);
    check({nm, "_go_pclk"},  32'(s.pclk_en), 1);
    check({nm, "_go_h"},     32'(s.h), 0);
    check({nm, "_go_v"},     32'(s.v), 0);
    check({nm, "_go_valid"}, 32'(s.valid), 1);
    check({nm, "_go_ls"},    32'(s.ls), 1);
    check({nm, "_go_fs"},    32'(s.fs), 1);
    @(negedge clk);
    s = snap(sel);
    check({nm, "_post_pclk"}, 32'(s.pclk_en), 0);
    check({nm, "_post_ls"},   32'(s.ls), 0);
    check({nm, "_post_fs"},   32'(s.fs), 0);
    check({nm, "_post_h"},    32'(s.h), 0);
  endtask

  // Advance to the pixel-enable cycle showing (h,v); an expired budget is a failed comparison.
  task automatic wait_pos(input bit sel, input int h, input int v, input int budget,
                          input string tag);
    snap_t s;
    bit    hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      s   = snap(sel);
      hit = s.pclk_en && (s.h == 10'(h)) && (s.v == 10'(v));
    end
    check({tag, "_reach"}, 32'(hit), 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t s;
    int    pulses, bad_gap, last_pulse;
    int    p, eh, ev, bad_cnt, bad_dec, bad_str, n_ls, n_fs;
    bit    epe;
`ifdef VGA_FRAME_CNT_EN
    int    timeouts;
    bit    seen;
`endif

    // Default instance: reset, startup, divider rate.
    repeat (5) @(negedge clk);
    check_reset_state(1'b0, "a", 799, 524, 1'b1);
    rst_a = 1'b0;
    check_startup(1'b0, "a", 4, 799, 524);

    pulses     = 0;
    bad_gap    = 0;
    last_pulse = 4;
    for (int c = 6; c <= 105; c++) begin
      @(negedge clk);
      if (vga_a.pclk_en) begin
        pulses++;
        if (c - last_pulse != 4) bad_gap++;
        last_pulse = c;
      end
    end
    check("a_div_pulses", pulses, 25);
    check("a_div_gaps", bad_gap, 0);
    check("a_div_hpos", 32'(vga_a.h_cnt), 25);

    // Horizontal boundaries on line 0.
    wait_pos(1'b0, 639, 0, 4000, "a_h639");
    check("a_valid_639", 32'(vga_a.valid), 1);
    wait_pos(1'b0, 640, 0, 8, "a_h640");
    check("a_valid_640", 32'(vga_a.valid), 0);
    wait_pos(1'b0, 655, 0, 80, "a_h655");
    check("a_hsync_655", 32'(vga_a.hsync), 1);
    wait_pos(1'b0, 656, 0, 8, "a_h656");
    check("a_hsync_656", 32'(vga_a.hsync), 0);
    wait_pos(1'b0, 751, 0, 400, "a_h751");
    check("a_hsync_751", 32'(vga_a.hsync), 0);
    wait_pos(1'b0, 752, 0, 8, "a_h752");
    check("a_hsync_752", 32'(vga_a.hsync), 1);
    wait_pos(1'b0, 799, 0, 200, "a_h799");
    check("a_ls_799", 32'(vga_a.line_start), 0);
    wait_pos(1'b0, 0, 1, 8, "a_line1");
    check("a_ls_line1", 32'(vga_a.line_start), 1);
    check("a_fs_line1", 32'(vga_a.frame_start), 0);
    @(negedge clk);
    check("a_ls_oneclk", 32'(vga_a.line_start), 0);

    // Mid-line reset on the default instance replays startup.
    wait_pos(1'b0, 300, 1, 1300, "a_mid");
    check("a_mid_valid", 32'(vga_a.valid), 1);
    #2 rst_a = 1'b1;
    #1 check_reset_state(1'b0, "a_mid", 799, 524, 1'b1);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    check_startup(1'b0, "a_re", 4, 799, 524);

    // Small instance: startup, then a full frame against a pixel model.
    check_reset_state(1'b1, "b", 7, 7, 1'b0);
    rst_b = 1'b0;
    check_startup(1'b1, "b", 2, 7, 7);

    bad_cnt = 0;
    bad_dec = 0;
    bad_str = 0;
    n_ls    = 0;
    n_fs    = 0;
    for (int k = 2; k <= 128; k++) begin
      @(negedge clk);
      s   = snap(1'b1);
      p   = k / 2;
      eh  = p % 8;
      ev  = (p / 8) % 8;
      epe = (k % 2) == 0;
      if (s.pclk_en !== epe || s.h !== 10'(eh) || s.v !== 10'(ev)) bad_cnt++;
      if (s.valid !== (eh < 4 && ev < 4) || s.hsync !== (eh >= 5 && eh <= 6) ||
          s.vsync !== (ev >= 5 && ev <= 6)) bad_dec++;
      if (s.ls !== (epe && eh == 0) || s.fs !== (epe && eh == 0 && ev == 0)) bad_str++;
      if (s.ls) n_ls++;
      if (s.fs) n_fs++;
    end
    check("b_frame_counters", bad_cnt, 0);
    check("b_frame_decodes", bad_dec, 0);
    check("b_frame_strobes", bad_str, 0);
    check("b_frame_lines", n_ls, 8);
    check("b_frame_fs_count", n_fs, 1);
    s = snap(1'b1);
    check("b_wrap_fs", 32'(s.fs), 1);
    check("b_wrap_h", 32'(s.h), 0);
    check("b_wrap_v", 32'(s.v), 0);

    // Mid-frame reset while vsync is active.
    wait_pos(1'b1, 3, 5, 256, "b_mid");
    check("b_mid_vsync", 32'(vga_b.vsync), 1);
    check("b_mid_valid", 32'(vga_b.valid), 0);
`ifdef VGA_FRAME_CNT_EN
    check("b_mid_fcnt", 32'(vga_b.frame_cnt), 2);
`endif
    #2 rst_b = 1'b1;
    #1 check_reset_state(1'b1, "b_mid", 7, 7, 1'b0);
`ifdef VGA_FRAME_CNT_EN
    check("b_rst_fcnt", 32'(vga_b.frame_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    check_startup(1'b1, "b_re", 2, 7, 7);

`ifdef VGA_FRAME_CNT_EN
    check("b_fcnt_first", 32'(vga_b.frame_cnt), 1);
    timeouts = 0;
    for (int f = 2; f <= 257; f++) begin
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
        @(negedge clk);
        seen = vga_b.frame_start;
      end
      if (!seen) timeouts++;
      if (f == 255) check("b_fcnt_255", 32'(vga_b.frame_cnt), 255);
      if (f == 256) check("b_fcnt_256", 32'(vga_b.frame_cnt), 0);
      if (f == 257) check("b_fcnt_257", 32'(vga_b.frame_cnt), 1);
    end
    check("b_fcnt_waits", timeouts, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
